bias_add_bank: RTL and testbench

BIAS_ADD_BANK -- requirements
Module: bias_add_bank

---
 rtl/bias_add_bank.sv | 168 ++++++++++++++++
 tb/tb_bias_add_bank.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_bank.sv
`default_nettype none
// ============================================================================
// Module   : bias_add_bank
// Brief    : Grouped bias store feeding N lanes of saturating adders, 1-cycle
//            latency with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module bias_add_bank #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int N_GROUPS     = 64,
  localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_start,
  input  logic                      ld_valid,
  input  logic [W-1:0]              ld_data,
  output logic                      ld_done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [GW-1:0]             in_group,
  input  logic [N_adder_tree*W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic [N_adder_tree-1:0]   out_sat
);

  localparam int            LW        = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(N_adder_tree - 1);
  localparam logic [GW-1:0] GRP_LAST  = GW'(N_GROUPS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [LW-1:0]               lane_cnt_q, lane_cnt_d;
  logic [GW-1:0]               grp_cnt_q, grp_cnt_d;
  logic                        ld_done_q, ld_done_d;
  logic                        out_valid_q;
  logic [N_adder_tree*W-1:0]   out_data_q;
  logic [N_adder_tree-1:0]     out_sat_q;

  logic [W-1:0]                bias_q [N_GROUPS][N_adder_tree];

  logic                        wr_en;
  logic                        wr_last;
  logic [LW-1:0]               wr_lane;
  logic [GW-1:0]               wr_grp;
  logic [GW-1:0]               rd_grp;
  logic                        xfer;
  logic [N_adder_tree*W-1:0]   sum_data;
  logic [N_adder_tree-1:0]     sum_sat;

  // A restart coinciding with a valid word lands that word at group 0, lane 0.
  assign wr_en   = (state_q == LOAD) && ld_valid;
  assign wr_lane = ld_start ? '0 : lane_cnt_q;
  assign wr_grp  = ld_start ? '0 : grp_cnt_q;
  assign wr_last = (wr_lane == LANE_LAST) && (wr_grp == GRP_LAST);

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    ld_done_d  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (ld_start) begin
          state_d    = LOAD;
          lane_cnt_d = '0;
          grp_cnt_d  = '0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          lane_cnt_d = '0;
          grp_cnt_d  = '0;
        end
        if (wr_en) begin
          if (wr_last) begin
            state_d    = READY;
            ld_done_d  = 1'b1;
            lane_cnt_d = '0;
            grp_cnt_d  = '0;
          end else if (wr_lane == LANE_LAST) begin
            lane_cnt_d = '0;
            grp_cnt_d  = wr_grp + 1'b1;
          end else begin
            lane_cnt_d = wr_lane + 1'b1;
            grp_cnt_d  = wr_grp;
          end
        end
      end
      READY: begin
        // Never start a reload while a result is still waiting to be taken.
        if (ld_start && !out_valid_q) begin
          state_d    = LOAD;
          lane_cnt_d = '0;
          grp_cnt_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      lane_cnt_q <= '0;
      grp_cnt_q  <= '0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      ld_done_q  <= ld_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bias_q[wr_grp][wr_lane] <= ld_data;
    end
  end

  assign rd_grp   = (int'(in_group) < N_GROUPS) ? in_group : '0;
  assign in_ready = (state_q == READY) && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  genvar i;
  generate
    for (i = 0; i < N_adder_tree; i++) begin : g_lane
      logic [W:0] sum;
      assign sum = {in_data[W*i+W-1], in_data[W*i +: W]}
                 + {bias_q[rd_grp][i][W-1], bias_q[rd_grp][i]};
      // Overflow at W bits shows up as disagreement of the two top sum bits.
      assign sum_sat[i] = sum[W] ^ sum[W-1];
      assign sum_data[W*i +: W] = !sum_sat[i] ? sum[W-1:0]
                                : sum[W]     ? {1'b1, {(W-1){1'b0}}}
                                             : {1'b0, {(W-1){1'b1}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sum_data;
      out_sat_q   <= sum_sat;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign ld_done   = ld_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_bias_add_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_add_bank
// Brief    : Scoreboard bench for bias_add_bank (16 lanes, 18 bits, 2 groups).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_add_bank;

  localparam int N    = 16;
  localparam int W    = 18;
  localparam int NG   = 2;
  localparam int GW   = 1;
  localparam int MAXV = 131071;
  localparam int MINV = -131072;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ld_start = 1'b0;
  logic           ld_valid = 1'b0;
  logic [W-1:0]   ld_data = '0;
  logic           ld_done;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [GW-1:0]  in_group = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_sat;

  int checks = 0;
  int errors = 0;
  int tb_bias [NG][N];
  logic [N+N*W-1:0] sb [$];
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  bias_add_bank #(.N_adder_tree(N), .W(W), .N_GROUPS(NG)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_group(in_group), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer sum clamped to the signed W-bit range.
  function automatic logic [N+N*W-1:0] model(input int g, input logic [N*W-1:0] d);
    logic [N*W-1:0] o;
    logic [N-1:0]   s;
    int             x;
    for (int i = 0; i < N; i++) begin
      x    = $signed(d[W*i +: W]) + tb_bias[g][i];
      s[i] = (x > MAXV) || (x < MINV);
      if (x > MAXV) x = MAXV;
      else if (x < MINV) x = MINV;
      o[W*i +: W] = x[W-1:0];
    end
    return {s, o};
  endfunction

  function automatic logic [N*W-1:0] splat(input int v);
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[W*i +: W] = W'(v);
    return d;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [N+N*W-1:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got sat=%h data=%h expected no beat", out_sat, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_sat, out_data} !== e) begin
          errors++;
          $display("FAIL out_beat: got sat=%h data=%h expected sat=%h data=%h",
                   out_sat, out_data, e[N+N*W-1 -: N], e[N*W-1:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom % 4) != 0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; leaves in_valid asserted so calls can stream.
  task automatic send(input int g, input logic [N*W-1:0] d, input logic [N+N*W-1:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_group = g[GW-1:0];
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (in_ready) sb.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
  endtask

  // Full load of tb_bias; restart_at >= 0 first streams that many junk words.
  task automatic load(input int restart_at);
    ld_start = 1'b1; ld_valid = 1'b0;
    @(posedge clk); #1;
    ld_start = 1'b0;
    if (restart_at >= 0) begin
      for (int k = 0; k < restart_at; k++) begin
        ld_valid = 1'b1; ld_data = W'(k * 7 + 3);
        @(negedge clk);
        chk("junk_in_ready", in_ready, 0);
        @(posedge clk); #1;
      end
      ld_start = 1'b1;
    end
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < N; i++) begin
        ld_valid = 1'b1; ld_data = W'(tb_bias[g][i]);
        @(negedge clk);
        chk("load_in_ready", in_ready, 0);
        chk("load_ld_done_early", ld_done, 0);
        @(posedge clk); #1;
        ld_start = 1'b0;
      end
    end
    ld_valid = 1'b0;
    @(negedge clk);
    chk("ld_done_pulse", ld_done, 1);
    chk("ready_after_load", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_done_once", ld_done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N*W-1:0]   d, ed, held;
    logic [N-1:0]     es;
    int               n;

    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_data_zero", out_data == '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    idle(2);

    for (int i = 0; i < N; i++) begin
      tb_bias[0][i] = (i == 0) ? 131000 : (i == 1) ? -131000 : (i == 2) ? 5 : i * 100 - 700;
      tb_bias[1][i] = (i % 2 == 0) ? -896 : 1164;
    end
    load(-1);

    // 1000 + (-896 | +1164)
    for (int i = 0; i < N; i++) ed[W*i +: W] = (i % 2 == 0) ? W'(104) : W'(2164);
    send(1, splat(1000), {{N{1'b0}}, ed});
    in_valid = 1'b0;
    @(negedge clk); chk("latency_out_valid", out_valid, 1);
    @(negedge clk); chk("out_valid_clears", out_valid, 0);
    @(posedge clk); #1;

    d = '0; d[W*0 +: W] = W'(200); d[W*1 +: W] = W'(-200); d[W*2 +: W] = W'(-5);
    for (int i = 0; i < N; i++) ed[W*i +: W] = W'(i * 100 - 700);
    ed[W*0 +: W] = W'(131071); ed[W*1 +: W] = W'(-131072); ed[W*2 +: W] = W'(0);
    es = 16'h0003;
    send(0, d, {es, ed});
    in_valid = 1'b0;
    idle(2);

    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          for (int i = 0; i < N; i++) d[W*i +: W] = W'(k * 1000 + i);
          send(k % 2, d, model(k % 2, d));
        end
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_out_valid", out_valid, 1);
        held = out_data;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid_hold", out_valid, 1);
          chk("bp_out_data_stable", out_data == held, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(2);

    out_ready = 1'b0;
    send(0, splat(-300), model(0, splat(-300)));
    in_valid = 1'b0;
    @(negedge clk); held = out_data;
    @(posedge clk); #1; ld_start = 1'b1;
    @(posedge clk); #1; ld_start = 1'b0;
    @(negedge clk);
    chk("ignst_out_valid", out_valid, 1);
    chk("ignst_out_data", out_data == held, 1);
    chk("ignst_ld_done", ld_done, 0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("ignst_still_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) ed[W*i +: W] = (i % 2 == 0) ? W'(104) : W'(2164);
    send(1, splat(1000), {{N{1'b0}}, ed});
    in_valid = 1'b0;
    idle(2);

    for (int i = 0; i < N; i++) begin
      tb_bias[0][i] = 1000 + i;
      tb_bias[1][i] = -(1000 + i);
    end
    load(10);
    for (int i = 0; i < N; i++) ed[W*i +: W] = W'(1000 - i);
    send(1, splat(2000), {{N{1'b0}}, ed});
    for (int i = 0; i < N; i++) ed[W*i +: W] = W'(-1000 + i);
    send(0, splat(-2000), {{N{1'b0}}, ed});
    in_valid = 1'b0;
    idle(2);

    out_ready = 1'b0;
    send(0, splat(7), model(0, splat(7)));
    in_valid = 1'b0;
    @(negedge clk); chk("held_before_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data_zero", out_data == '0, 1);
    chk("async_rst_in_ready", in_ready, 0);
    sb.delete();
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_group = '0;
    @(negedge clk); chk("empty_after_rst_in_ready", in_ready, 0);
    @(posedge clk); #1; in_valid = 1'b0;

    ld_start = 1'b1;
    @(posedge clk); #1; ld_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ld_valid = 1'b1; ld_data = W'(k);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midload_rst_in_ready", in_ready, 0);
    chk("midload_rst_out_valid", out_valid, 0);
    chk("midload_rst_ld_done", ld_done, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ld_valid = 1'b1; ld_data = W'(k);
      @(negedge clk);
      chk("empty_ignores_ld_valid", {ld_done, in_ready}, 0);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;

    for (int i = 0; i < N; i++) begin
      tb_bias[0][i] = ((i % 2 == 0) ? 100000 : -100000) + 3 * i;
      tb_bias[1][i] = i * 1000 - 8000;
    end
    load(-1);
    for (int i = 0; i < N; i++) begin
      ed[W*i +: W] = (i % 2 == 0) ? W'(131071) : W'(-50000 + 3 * i);
      es[i] = (i % 2 == 0);
    end
    send(0, splat(50000), {es, ed});
    for (int i = 0; i < N; i++) begin
      ed[W*i +: W] = (i <= 6) ? W'(-131072) : W'(-138000 + 1000 * i);
      es[i] = (i <= 6);
    end
    send(1, splat(-130000), {es, ed});
    // Exact-boundary sums on lanes 6..10 (biases -2000..+2000).
    d = '0;
    d[W*6 +: W] = W'(-129073); d[W*7 +: W] = W'(-130072); d[W*8 +: W] = W'(131071);
    d[W*9 +: W] = W'(130071);  d[W*10 +: W] = W'(129072);
    for (int i = 0; i < N; i++) ed[W*i +: W] = W'(i * 1000 - 8000);
    ed[W*6 +: W] = W'(-131072); ed[W*7 +: W] = W'(-131072); ed[W*8 +: W] = W'(131071);
    ed[W*9 +: W] = W'(131071);  ed[W*10 +: W] = W'(131071);
    es = '0; es[6] = 1'b1; es[10] = 1'b1;
    send(1, d, {es, ed});
    in_valid = 1'b0;
    idle(2);

    rand_rdy = 1'b1;
    for (int t = 0; t < 10000; t++) begin
      int g;
      if ($urandom % 4 == 0) begin
        in_valid = 1'b0;
        idle(1);
      end
      g = $urandom % 2;
      for (int i = 0; i < N; i++) d[W*i +: W] = W'($urandom);
      send(g, d, model(g, d));
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #2; out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
